// File: rtl/mest_pro_pkg.sv
// mest_pro_pkg: shared types and constants for the MESTPro sequencer.
// Opcodes are plain ints, cast to OPC_W bits where used.
package mest_pro_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE,
    S_ERROR
  } state_e;

  // HALT is all ones at any opcode width: OPC_W'(-1).
  localparam int OPC_HALT = -1;
  localparam int OPC_JMP  = 'hC;
  localparam int OPC_JZ   = 'hD;
  localparam int OPC_CALL = 'hE;
  localparam int OPC_RET  = 'hB;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  function automatic logic [1:0] stack_err(input logic is_call);
    return is_call ? ERR_OVF : ERR_UNF;
  endfunction

endpackage

// File: rtl/mest_pro_if.sv
// mest_pro_if: fetch req/ack and dispatch valid/done bundle.
// master = sequencer, slave = memory plus exec unit.
interface mest_pro_if #(
  parameter int OPC_W   = 4,
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 12
) ();

  logic                     o_req;
  logic [ADDR_W-1:0]        o_prog_counter;
  logic                     i_ack;
  logic [INSTR_W-1:0]       i_instruction;
  logic                     o_exec_valid;
  logic [OPC_W-1:0]         o_op_code;
  logic [INSTR_W-OPC_W-1:0] o_operand;
  logic                     i_exec_done;
  logic                     i_zero_flag;

  modport master (
    output o_req, o_prog_counter,
    output o_exec_valid, o_op_code, o_operand,
    input  i_ack, i_instruction,
    input  i_exec_done, i_zero_flag
  );

  modport slave (
    input  o_req, o_prog_counter,
    input  o_exec_valid, o_op_code, o_operand,
    output i_ack, i_instruction,
    output i_exec_done, i_zero_flag
  );

endinterface

// File: rtl/mest_pro_call_stack.sv
// mest_pro_call_stack: bounded LIFO of return addresses.
// Push on full / pop on empty are ignored; popped entries are kept.
module mest_pro_call_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // Occupancy update; clear wins over push/pop.
  always_comb begin
    level_d = level_q;
    if (clear_i)
      level_d = '0;
    else if (do_push)
      level_d = level_q + LVL_W'(1);
    else if (do_pop)
      level_d = level_q - LVL_W'(1);
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst_i)
      level_q <= '0;
    else
      level_q <= level_d;
  end

  // Entry storage, written at the current top slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && level_q == LVL_W'(i))
        mem_q[i] <= din_i;
    end
  end

  // Top-of-stack read mux.
  always_comb begin
    dout_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level_q == LVL_W'(i + 1))
        dout_o = mem_q[i];
    end
  end

endmodule

// File: rtl/mest_pro_seq.sv
// mest_pro_seq: multi-cycle fetch/decode/dispatch sequencer.
// Control flow resolved locally; other opcodes go to exec.
module mest_pro_seq
  import mest_pro_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int INSTR_W     = 16,
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  mest_pro_if.master       bus,
  output logic             o_busy,
  output logic             o_all_done,
  output logic             o_error,
  output logic [1:0]       o_error_code,
  output logic [LVL_W-1:0] o_stack_level
);

  localparam int OPR_W = INSTR_W - OPC_W;
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);
  localparam logic [OPC_W-1:0] C_HALT = OPC_W'(OPC_HALT);
  localparam logic [OPC_W-1:0] C_JMP  = OPC_W'(OPC_JMP);
  localparam logic [OPC_W-1:0] C_JZ   = OPC_W'(OPC_JZ);
  localparam logic [OPC_W-1:0] C_CALL = OPC_W'(OPC_CALL);
  localparam logic [OPC_W-1:0] C_RET  = OPC_W'(OPC_RET);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               zero_q, zero_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [1:0]         err_q, err_d;

  logic [OPC_W-1:0]   opc;
  logic [ADDR_W-1:0]  k;
  logic [ADDR_W-1:0]  pc_inc;
  logic               stk_push;
  logic               stk_pop;
  logic               stk_clr;
  logic [ADDR_W-1:0]  stk_dout;
  logic               stk_full;
  logic               stk_empty;

  assign opc    = ir_q[INSTR_W-1 -: OPC_W];
  assign k      = ir_q[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  mest_pro_call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk     (clk),
    .rst_i   (i_reset),
    .clear_i (stk_clr),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .din_i   (pc_inc),
    .dout_o  (stk_dout),
    .level_o (o_stack_level),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // Next-state, PC and stack control.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    zero_d   = zero_q;
    ir_d     = ir_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_FETCH;
          pc_d    = PC0;
          zero_d  = 1'b0;
          stk_clr = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.i_ack) begin
          ir_d    = bus.i_instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (opc)
          C_HALT: state_d = S_DONE;
          C_JMP: begin
            pc_d    = k;
            state_d = S_FETCH;
          end
          C_JZ: begin
            pc_d    = zero_q ? k : pc_inc;
            state_d = S_FETCH;
          end
          C_CALL: begin
            if (stk_full) begin
              err_d   = stack_err(1'b1);
              state_d = S_ERROR;
            end else begin
              stk_push = 1'b1;
              pc_d     = k;
              state_d  = S_FETCH;
            end
          end
          C_RET: begin
            if (stk_empty) begin
              err_d   = stack_err(1'b0);
              state_d = S_ERROR;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_dout;
              state_d = S_FETCH;
            end
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (bus.i_exec_done) begin
          zero_d  = bus.i_zero_flag;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC0;
      zero_q  <= 1'b0;
      ir_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_req          = (state_q == S_FETCH);
  assign bus.o_prog_counter = pc_q;
  assign bus.o_exec_valid   = (state_q == S_EXEC);
  assign bus.o_op_code      = opc;
  assign bus.o_operand      = ir_q[OPR_W-1:0];

  assign o_busy = (state_q == S_FETCH) ||
                  (state_q == S_DECODE) ||
                  (state_q == S_EXEC);
  assign o_all_done   = (state_q == S_DONE);
  assign o_error      = (state_q == S_ERROR);
  assign o_error_code = err_q;

endmodule

// File: tb/tb_mest_pro_seq.sv
// tb_mest_pro_seq: directed plus randomized checks of mest_pro_seq
// against an instruction-level model of the program.
module tb_mest_pro_seq;
  import mest_pro_pkg::*;

  localparam int OPC_W   = 4;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 12;
  localparam int DEPTH   = 8;
  localparam int RST_PC  = 0;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic       o_busy;
  logic       o_all_done;
  logic       o_error;
  logic [1:0] o_error_code;
  logic [3:0] o_stack_level;

  always #5 clk = ~clk;

  mest_pro_if #(
    .OPC_W(OPC_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W)
  ) bus ();

  mest_pro_seq #(
    .OPC_W(OPC_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W),
    .STACK_DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .bus           (bus),
    .o_busy        (o_busy),
    .o_all_done    (o_all_done),
    .o_error       (o_error),
    .o_error_code  (o_error_code),
    .o_stack_level (o_stack_level)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] pmem [4096];
  int fetch_waits[$];
  int exec_delays[$];
  bit zero_flags[$];

  int m_pc;
  bit m_zero;
  int m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int kk);
    logic [15:0] w;
    w[15:12] = op[3:0];
    w[11:0]  = kk[11:0];
    return w;
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 4096; i++) pmem[i] = 16'hF000;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_req"}, bus.o_req, 0);
    chk({tag, "_pc"}, bus.o_prog_counter, RST_PC);
    chk({tag, "_valid"}, bus.o_exec_valid, 0);
    chk({tag, "_op"}, bus.o_op_code, 0);
    chk({tag, "_opr"}, bus.o_operand, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_all_done, 0);
    chk({tag, "_err"}, o_error, 0);
    chk({tag, "_code"}, o_error_code, 0);
    chk({tag, "_lvl"}, o_stack_level, 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    bus.i_ack = 1'($urandom_range(0, 1));
    bus.i_exec_done = 1'b1;
    @(negedge clk);
    chk_idle_outs("rst");
    i_reset = 1'b0;
    bus.i_ack = 1'b0;
    bus.i_exec_done = 1'b0;
    @(negedge clk);
    chk("idle_hold_req", bus.o_req, 0);
  endtask

  task automatic run_prog(input int max_instr);
    logic [15:0] w16;
    int opc, kk, w, d, code;
    bit z;
    m_pc = RST_PC;
    m_zero = 1'b0;
    m_stk.delete();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 0; n < max_instr; n++) begin
      chk("fetch_req", bus.o_req, 1);
      chk("fetch_novalid", bus.o_exec_valid, 0);
      chk("fetch_pc", bus.o_prog_counter, m_pc);
      chk("level", o_stack_level, m_stk.size());
      chk("busy", o_busy, 1);
      w = (fetch_waits.size() > 0) ? fetch_waits.pop_front()
                                   : int'($urandom_range(0, 3));
      for (int j = 0; j < w; j++) begin
        bus.i_exec_done = 1'($urandom_range(0, 1));
        bus.i_instruction = 16'($urandom);
        @(negedge clk);
        chk("req_hold", bus.o_req, 1);
        chk("pc_stable", bus.o_prog_counter, m_pc);
      end
      w16 = pmem[m_pc];
      bus.i_ack = 1'b1;
      bus.i_instruction = w16;
      bus.i_exec_done = 1'b0;
      @(negedge clk);
      bus.i_ack = 1'b0;
      bus.i_instruction = 16'($urandom);
      chk("decode_noreq", bus.o_req, 0);
      chk("decode_novalid", bus.o_exec_valid, 0);
      opc = int'(w16[15:12]);
      kk = int'(w16[11:0]);
      if (opc == 15) begin
        @(negedge clk);
        chk("all_done", o_all_done, 1);
        chk("halt_busy", o_busy, 0);
        chk("halt_pc", bus.o_prog_counter, m_pc);
        chk("halt_lvl", o_stack_level, m_stk.size());
        return;
      end
      code = 0;
      if (opc == 14 && m_stk.size() == DEPTH) code = 1;
      if (opc == 11 && m_stk.size() == 0) code = 2;
      if (code != 0) begin
        @(negedge clk);
        chk("error", o_error, 1);
        chk("err_code", o_error_code, code);
        chk("err_lvl", o_stack_level, m_stk.size());
        chk("err_req", bus.o_req, 0);
        return;
      end
      if (opc >= 11 && opc <= 14) begin
        case (opc)
          12: m_pc = kk;
          13: m_pc = m_zero ? kk : (m_pc + 1) % 4096;
          14: begin
            m_stk.push_back((m_pc + 1) % 4096);
            m_pc = kk;
          end
          default: m_pc = m_stk.pop_back();
        endcase
        @(negedge clk);
      end else begin
        @(negedge clk);
        chk("exec_valid", bus.o_exec_valid, 1);
        chk("exec_op", bus.o_op_code, w16[15:12]);
        chk("exec_opr", bus.o_operand, w16[11:0]);
        d = (exec_delays.size() > 0) ? exec_delays.pop_front()
                                     : int'($urandom_range(0, 4));
        for (int j = 0; j < d; j++) begin
          bus.i_ack = 1'($urandom_range(0, 1));
          bus.i_zero_flag = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("valid_hold", bus.o_exec_valid, 1);
          chk("op_stable", bus.o_op_code, w16[15:12]);
          chk("opr_stable", bus.o_operand, w16[11:0]);
        end
        z = (zero_flags.size() > 0) ? zero_flags.pop_front()
                                    : 1'($urandom_range(0, 1));
        bus.i_ack = 1'b0;
        bus.i_exec_done = 1'b1;
        bus.i_zero_flag = z;
        @(negedge clk);
        bus.i_exec_done = 1'b0;
        bus.i_zero_flag = 1'($urandom_range(0, 1));
        m_zero = z;
        m_pc = (m_pc + 1) % 4096;
      end
    end
    do_reset();
  endtask

  initial begin
    int r;
    i_reset = 1'b1;
    i_start = 1'b0;
    bus.i_ack = 1'b0;
    bus.i_instruction = '0;
    bus.i_exec_done = 1'b0;
    bus.i_zero_flag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle_outs("por");
    i_reset = 1'b0;
    @(negedge clk);

    fill_halt();
    pmem[0] = ins(1, 'h123);
    pmem[1] = ins(2, 'h045);
    fetch_waits = '{3, 3, 3};
    run_prog(10);

    fill_halt();
    pmem[0] = ins(3, 'hABC);
    pmem[1] = ins(4, 'h5A5);
    exec_delays = '{0, 5};
    run_prog(10);

    fill_halt();
    pmem[0] = ins(5, 1);
    pmem[1] = ins(13, 'h020);
    pmem['h20] = ins(6, 2);
    pmem['h21] = ins(13, 'h040);
    zero_flags = '{1'b1, 1'b0};
    run_prog(10);

    fill_halt();
    pmem[0] = ins(14, 'h010);
    pmem['h10] = ins(14, 'h020);
    pmem['h20] = ins(14, 'h030);
    pmem['h30] = ins(11, 0);
    pmem['h21] = ins(11, 0);
    pmem['h11] = ins(11, 0);
    pmem[1] = ins(14, 'h050);
    run_prog(20);

    fill_halt();
    for (int i = 0; i < 9; i++) pmem[i] = ins(14, i + 1);
    run_prog(20);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    chk("err_sticky", o_error, 1);
    chk("err_sticky_code", o_error_code, 1);
    chk("err_sticky_req", bus.o_req, 0);
    chk("err_sticky_lvl", o_stack_level, 8);
    do_reset();
    fill_halt();
    pmem[0] = ins(11, 0);
    run_prog(5);
    do_reset();

    fill_halt();
    pmem[0] = ins(12, 'hFFF);
    pmem['hFFF] = ins(7, 'h777);
    run_prog(3);

    fill_halt();
    pmem[0] = ins(8, 'h0F0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    bus.i_ack = 1'b1;
    bus.i_instruction = pmem[0];
    @(negedge clk);
    bus.i_ack = 1'b0;
    @(negedge clk);
    chk("rst_exec_valid", bus.o_exec_valid, 1);
    do_reset();

    for (int t = 0; t < 6; t++) begin
      fill_halt();
      for (int a = 0; a < 64; a++) begin
        r = int'($urandom_range(0, 99));
        if (r < 55)
          pmem[a] = ins(int'($urandom_range(0, 10)), int'($urandom));
        else if (r < 65)
          pmem[a] = ins(12, int'($urandom_range(0, 63)));
        else if (r < 75)
          pmem[a] = ins(13, int'($urandom_range(0, 63)));
        else if (r < 85)
          pmem[a] = ins(14, int'($urandom_range(0, 63)));
        else if (r < 95)
          pmem[a] = ins(11, 0);
        else
          pmem[a] = ins(15, 0);
      end
      run_prog(150);
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mest_pro_seq.md
Name: mest_pro_seq

Overview:
Parametrised multi-cycle instruction sequencer for the next-generation MESTPro core. It replaces the fixed-width controller and fetch pair with a single block that has the following features:
- generic PC width and instruction width
- a req/ack fetch handshake that tolerates wait states
- a bounded hardware call/return stack
- a valid/done dispatch handshake to the execute unit

Control-flow opcodes are resolved locally. All other opcodes are forwarded to the exec unit.

Parameters:
OPC_W, 4, opcode width (top bits of instruction)
INSTR_W, 16, instruction width; operand field = INSTR_W-OPC_W bits
ADDR_W, 12, program counter width; must be <= INSTR_W-OPC_W
STACK_DEPTH, 8, call-stack entries, >= 1
RESET_PC, 0, PC value after reset and on each start

Ports:
clk  in  1  system clock, rising edge
i_reset  in  1  synchronous reset, active-high
i_start  in  1  begin execution from RESET_PC; honoured only in IDLE or DONE
o_req  out  1  fetch request, held until i_ack
o_prog_counter  out  ADDR_W  fetch address, stable while o_req=1
i_ack  in  1  instruction memory ack; i_instruction valid in the same cycle
i_instruction  in  INSTR_W  fetched word
o_exec_valid  out  1  dispatch to exec unit, held until i_exec_done
o_op_code  out  OPC_W  registered opcode, stable while o_exec_valid=1
o_operand  out  INSTR_W-OPC_W  registered operand field
i_exec_done  in  1  exec completion; may be asserted in the same cycle as o_exec_valid rises
i_zero_flag  in  1  exec zero flag, sampled when i_exec_done=1
o_busy  out  1  high in FETCH/DECODE/EXEC
o_all_done  out  1  high in DONE
o_error  out  1  high in ERROR
o_error_code  out  2  01 = stack overflow, 10 = stack underflow, 00 = none
o_stack_level  out  $clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- FSM states: IDLE, FETCH, DECODE, EXEC, DONE, ERROR.
- Reset (synchronous, any state, mid-fetch or mid-dispatch included):
  - state=IDLE, PC=RESET_PC, stack level=0, zero_q=0.
  - All outputs 0; o_prog_counter=RESET_PC.
  - A pending i_ack or i_exec_done in the reset cycle is ignored.
- IDLE: on i_start -> FETCH, PC=RESET_PC, zero_q=0.
- FETCH:
  - o_req=1 every cycle in this state.
  - On i_ack: latch i_instruction into the instruction register -> DECODE.
  - Minimum 1 cycle in FETCH; wait states are unbounded.
- DECODE (1 cycle): split into opcode and operand; K = operand[ADDR_W-1:0]. Resolve as follows.
  - HALT (all ones) -> DONE; PC unchanged.
  - JMP (OPC_W'hC): PC=K -> FETCH.
  - JZ (OPC_W'hD): if zero_q then PC=K, else PC=PC+1 -> FETCH.
  - CALL (OPC_W'hE):
    - If level==STACK_DEPTH -> ERROR, code 01; PC and stack unchanged.
    - Else push PC+1, PC=K -> FETCH.
  - RET (OPC_W'hB):
    - If level==0 -> ERROR, code 10.
    - Else PC=pop -> FETCH.
  - Any other opcode -> EXEC.
- EXEC:
  - o_exec_valid=1, o_op_code and o_operand held constant.
  - On i_exec_done: zero_q=i_zero_flag, PC=PC+1 -> FETCH.
- PC increment wraps modulo 2^ADDR_W (max -> 0); no error. The pushed return address wraps the same way.
- Cycle counts with zero-wait ack:
  - Local control-flow instruction: 2 cycles (FETCH, DECODE).
  - Dispatched instruction with same-cycle done: 3 cycles.
- DONE:
  - o_all_done=1; the stack is retained.
  - i_start restarts as in IDLE and clears the stack.
- ERROR:
  - Sticky: o_error=1, o_error_code held, o_req=0, o_exec_valid=0.
  - Left only via i_reset; i_start is ignored.
- i_start outside IDLE/DONE is ignored. i_ack outside FETCH and i_exec_done outside EXEC are ignored.
- Stack: LIFO register array, STACK_DEPTH x ADDR_W. Entries are not cleared on pop.

Decomposition:
- mest_pro_pkg holds:
  - state enum
  - opcode localparams OPC_HALT, OPC_JMP, OPC_JZ, OPC_CALL, OPC_RET (expressed relative to OPC_W)
  - error-code constants ERR_NONE, ERR_OVF, ERR_UNF
- One sub-module, mest_pro_call_stack, with parameters DEPTH and WIDTH:
  - ports push, pop, din, dout, level, full, empty
  - push on full and pop on empty are no-ops
  - simultaneous push+pop is never issued by the sequencer

Test Plan:
- Fetch wait states: ack delayed 3 cycles on each of PC 0,1,2. Program is 2 exec ops then HALT. Required: o_req held 4 cycles per fetch; o_prog_counter stable; o_all_done after HALT; final PC=2.
- Exec handshake: exec op at PC 0 with done in the same cycle, then an exec op with done 5 cycles late. Required: o_exec_valid lasts 1 and 6 cycles; o_op_code and o_operand constant while valid.
- Branches: exec returns zero=1, JZ K=0x020 is taken; next exec returns zero=0, JZ K=0x040 is not taken. Required: fetch addresses 0x020, then current PC+1.
- Call nesting: CALL depth 3 then 3 RETs with STACK_DEPTH=8. Required: o_stack_level goes 1,2,3,2,1,0; each RET returns to its CALL address+1.
- Stack faults: 9 nested CALLs with STACK_DEPTH=8 -> o_error=1, code 01, level stays 8. After i_reset, a RET at PC 0 -> code 10.
- Reset and wrap:
  - JMP to 0xFFF holding an exec op -> next fetch at 0x000.
  - i_reset asserted in EXEC with done pending -> next cycle IDLE, all outputs 0, PC=RESET_PC.
